riscv_retire_monitor: RTL

Synthesizable retire/halt monitor that sits directly downstream of the riscv_stub pipeline. It consumes the core's fetch PC and MEM/WB writeback stream. It keeps a shadow architectural register file, counts cycles and retired writes, and flags halt (PC stuck in a jump-to-self loop) or timeout. Simulation benches and future FPGA bring-up use it to check end-of-program state through ports instead of hierarchical references.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/shadow_regfile.sv | 32 +++
 rtl/riscv_retire_monitor.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the riscv_stub retire monitor.
package riscv_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } mon_state_e;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow architectural register file: one synchronous write port with x0
// gating, one combinational read port, synchronous active-high reset.
module shadow_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Reads see the pre-edge contents; x0 is hardwired to zero.
    assign o_rd_data = (i_rd_addr == '0) ? '0 : r_regs[i_rd_addr];

endmodule

// File: rtl/riscv_retire_monitor.sv
// Retire/halt monitor: shadows writebacks, counts cycles and retires, and
// flags a jump-to-self halt or a run timeout.
module riscv_retire_monitor
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned HALT_COUNT     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 500,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  halted,
    output logic                  timeout,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] halt_pc,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [CNT_WIDTH-1:0]  retire_count
);

    localparam int unsigned SAME_W = $clog2(HALT_COUNT + 1);

    mon_state_e            r_state;
    mon_state_e            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_last_pc;
    logic [DATA_WIDTH-1:0] r_halt_pc;
    logic [SAME_W-1:0]     r_same_cnt;
    logic [SAME_W-1:0]     w_same_cnt_nxt;
    logic [CNT_WIDTH-1:0]  r_cycle_count;
    logic [CNT_WIDTH-1:0]  r_retire_count;
    logic                  r_halted;
    logic                  r_timeout;
    logic                  w_active;
    logic                  w_halt_hit;
    logic                  w_timeout_hit;
    logic                  w_retire;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, same-PC comparison and terminal-event detection.
    always_comb begin
        w_state_nxt    = r_state;
        w_same_cnt_nxt = '0;
        w_halt_hit     = 1'b0;
        w_active       = (r_state == WAIT) || (r_state == RUN);
        w_timeout_hit  = w_active &&
                         (r_cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

        case (r_state)
            WAIT: begin
                w_state_nxt = RUN;
            end
            RUN: begin
                if (pc == r_last_pc) begin
                    w_same_cnt_nxt = r_same_cnt + SAME_W'(1);
                end
                w_halt_hit = (pc == r_last_pc) &&
                             (w_same_cnt_nxt == SAME_W'(HALT_COUNT));
                if (w_halt_hit) begin
                    w_state_nxt = HALTED;
                end
            end
            default: begin
            end
        endcase

        // A halt on the same edge takes priority over the timeout.
        if (w_timeout_hit && !w_halt_hit) begin
            w_state_nxt = TIMEOUT;
        end
    end

    assign w_retire = w_active && wb_we && (wb_rd != '0);

    // Datapath registers; everything freezes once a terminal state is entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_pc      <= '0;
            r_same_cnt     <= '0;
            r_cycle_count  <= '0;
            r_retire_count <= '0;
            r_halt_pc      <= '0;
            r_halted       <= 1'b0;
            r_timeout      <= 1'b0;
        end else if (w_active) begin
            r_last_pc  <= pc;
            r_same_cnt <= w_same_cnt_nxt;
            if (r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end
            if (w_retire && (r_retire_count != '1)) begin
                r_retire_count <= r_retire_count + CNT_WIDTH'(1);
            end
            if (w_halt_hit) begin
                r_halted  <= 1'b1;
                r_halt_pc <= pc;
            end else if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    shadow_regfile #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shadow_regfile (
        .clk       (clk),
        .i_reset   (reset),
        .i_wr_en   (w_active && wb_we),
        .i_wr_addr (wb_rd),
        .i_wr_data (wb_data),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign halted       = r_halted;
    assign timeout      = r_timeout;
    assign done         = r_halted || r_timeout;
    assign halt_pc      = r_halt_pc;
    assign cycle_count  = r_cycle_count;
    assign retire_count = r_retire_count;

endmodule
